// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode-register
// field positions, error bit indices and mode decode helpers.
package sdram_responder_pkg;

  // {ras, cas, we} as driven by the controller when cs_n is low.
  typedef enum logic [2:0] {
    CmdMrs   = 3'b000,
    CmdAr    = 3'b001,
    CmdPre   = 3'b010,
    CmdAct   = 3'b011,
    CmdWrite = 3'b100,
    CmdRead  = 3'b101,
    CmdBst   = 3'b110,
    CmdNop   = 3'b111
  } sdram_cmd_e;

  // Mode register fields carried on address[] during MRS.
  localparam int unsigned ModeBlLsb = 0;
  localparam int unsigned ModeBlMsb = 2;
  localparam int unsigned ModeBtBit = 3;
  localparam int unsigned ModeClLsb = 4;
  localparam int unsigned ModeClMsb = 6;

  // Sticky error flag positions.
  localparam int unsigned ErrActActive = 0;
  localparam int unsigned ErrRwIdle    = 1;
  localparam int unsigned ErrArActive  = 2;
  localparam int unsigned ErrMode      = 3;

  // Supported: BL 1/2/4/8, sequential burst type, CL 2 or 3.
  function automatic logic mode_supported(input logic [11:0] mode);
    logic [2:0] bl;
    logic [2:0] cl;
    bl = mode[ModeBlMsb:ModeBlLsb];
    cl = mode[ModeClMsb:ModeClLsb];
    return (bl[2] == 1'b0) && (mode[ModeBtBit] == 1'b0) && ((cl == 3'd2) || (cl == 3'd3));
  endfunction

  // Burst length minus one; doubles as the column wrap mask.
  function automatic logic [2:0] burst_len_m1(input logic [1:0] bl_code);
    logic [2:0] len_m1;
    unique case (bl_code)
      2'd0:    len_m1 = 3'd0;
      2'd1:    len_m1 = 3'd1;
      2'd2:    len_m1 = 3'd3;
      default: len_m1 = 3'd7;
    endcase
    return len_m1;
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM pin bus between a controller (master) and the responder (slave).
//   cke, cs_n, ras, cas, we : command bus
//   address, bank           : row / column / mode value and bank select
//   data_in, data_mask      : write data and byte mask (1 = suppress byte)
//   data_out, data_oe       : read data and its valid / drive enable
//   error_flags             : sticky protocol violation bits
//   refresh_count           : accepted AUTO REFRESH commands, wrapping
interface sdram_responder_if;
  logic        cke;
  logic        cs_n;
  logic        ras;
  logic        cas;
  logic        we;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in;
  logic [1:0]  data_mask;
  logic [15:0] data_out;
  logic        data_oe;
  logic [3:0]  error_flags;
  logic [15:0] refresh_count;

  modport master (
    output cke, cs_n, ras, cas, we, address, bank, data_in, data_mask,
    input  data_out, data_oe, error_flags, refresh_count
  );

  modport slave (
    input  cke, cs_n, ras, cas, we, address, bank, data_in, data_mask,
    output data_out, data_oe, error_flags, refresh_count
  );
endinterface

// File: rtl/sdram_responder_mem.sv
// Single-port synchronous RAM, 16-bit words with two byte enables.
//   clk     : clock
//   i_en    : access enable; o_rdata holds when low
//   i_we    : 1 = write enabled bytes, 0 = read into o_rdata
//   i_be    : byte enables, bit n covers data[8n+7:8n]
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, one cycle after the read access
module sdram_responder_mem #(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [1:0]           i_be,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [15:0]          i_wdata,
  output logic [15:0]          o_rdata
);
  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [15:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model for a 12-bit-address, 4-bank, x16 SDR part backed by block RAM.
//   clk : device clock (controller's SDRAM clock)
//   rst : synchronous active-high reset; RAM contents survive it
//   bus : slave side of sdram_responder_if (command bus in, read data and status out)
// Read data for a READ accepted on edge E0 is on the bus ready for edge E0+CL.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 8
) (
  input logic              clk,
  input logic              rst,
  sdram_responder_if.slave bus
);
  localparam int unsigned AddrBits = 2 + ROW_BITS + COL_BITS;

  // Bank tracker and mode register
  logic [3:0]          r_bank_active;
  logic [ROW_BITS-1:0] r_open_row [4];
  logic                r_mode_valid;
  logic [1:0]          r_bl_code;
  logic                r_cl3;
  logic [3:0]          r_err;
  logic [15:0]         r_refresh_count;

  // Burst generator; r_burst_idx is the index of the next beat to issue
  logic                r_burst_active;
  logic                r_burst_wr;
  logic [1:0]          r_burst_bank;
  logic [ROW_BITS-1:0] r_burst_row;
  logic [COL_BITS-1:0] r_burst_col;
  logic [2:0]          r_burst_idx;
  logic [2:0]          r_burst_len_m1;

  // Read pipeline: RAM output stage, optional middle stage (CL3), output stage
  logic                r_ram_v;
  logic                r_mid_v;
  logic [15:0]         r_mid_d;
  logic                r_data_oe;
  logic [15:0]         r_data_out;

  sdram_cmd_e          w_cmd;
  logic                w_cmd_en;
  logic                w_bank_open;
  logic                w_rw_ok;
  logic                w_wr_start;
  logic                w_stop;
  logic                w_burst_beat;
  logic [2:0]          w_beat_low;
  logic [COL_BITS-1:0] w_beat_col;
  logic                w_ram_en;
  logic                w_ram_we;
  logic [AddrBits-1:0] w_ram_addr;
  logic [1:0]          w_ram_be;
  logic [15:0]         w_ram_rdata;
  logic                w_rd_issue;
  logic                w_out_v;
  logic [15:0]         w_out_d;

  assign w_cmd       = sdram_cmd_e'({bus.ras, bus.cas, bus.we});
  assign w_cmd_en    = bus.cke & ~bus.cs_n;
  assign w_bank_open = r_bank_active[bus.bank];
  assign w_rw_ok     = w_cmd_en && ((w_cmd == CmdRead) || (w_cmd == CmdWrite)) &&
                       w_bank_open && r_mode_valid;
  assign w_wr_start  = w_rw_ok && (w_cmd == CmdWrite);
  assign w_stop      = w_cmd_en && ((w_cmd == CmdBst) ||
                       ((w_cmd == CmdPre) && (bus.address[10] || (bus.bank == r_burst_bank))));
  // A terminating command on an edge blocks the beat that edge would have issued.
  assign w_burst_beat = bus.cke && r_burst_active && !w_rw_ok && !w_stop;

  // Sequential burst order: low column bits wrap inside the BL-aligned block.
  always_comb begin
    w_beat_low      = r_burst_col[2:0] + r_burst_idx;
    w_beat_col      = r_burst_col;
    w_beat_col[2:0] = (r_burst_col[2:0] & ~r_burst_len_m1) | (w_beat_low & r_burst_len_m1);
  end

  always_comb begin
    w_ram_en   = !rst && (w_rw_ok || w_burst_beat);
    w_ram_we   = w_rw_ok ? (w_cmd == CmdWrite) : r_burst_wr;
    w_ram_addr = w_rw_ok ? {bus.bank, r_open_row[bus.bank], bus.address[COL_BITS-1:0]}
                         : {r_burst_bank, r_burst_row, w_beat_col};
    w_ram_be   = ~bus.data_mask;
    w_rd_issue = w_ram_en && !w_ram_we;
    w_out_v    = r_cl3 ? r_mid_v : r_ram_v;
    w_out_d    = r_cl3 ? r_mid_d : w_ram_rdata;
  end

  sdram_responder_mem #(
    .ADDR_BITS(AddrBits)
  ) u_mem (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_be   (w_ram_be),
    .i_addr (w_ram_addr),
    .i_wdata(bus.data_in),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_active   <= '0;
      for (int i = 0; i < 4; i++) r_open_row[i] <= '0;
      r_mode_valid    <= 1'b0;
      r_bl_code       <= '0;
      r_cl3           <= 1'b0;
      r_err           <= '0;
      r_refresh_count <= '0;
      r_burst_active  <= 1'b0;
      r_burst_wr      <= 1'b0;
      r_burst_bank    <= '0;
      r_burst_row     <= '0;
      r_burst_col     <= '0;
      r_burst_idx     <= '0;
      r_burst_len_m1  <= '0;
      r_ram_v         <= 1'b0;
      r_mid_v         <= 1'b0;
      r_mid_d         <= '0;
      r_data_oe       <= 1'b0;
      r_data_out      <= '0;
    end else if (bus.cke) begin
      // Command decode and bank tracking
      if (w_cmd_en) begin
        case (w_cmd)
          CmdAct: begin
            if (w_bank_open) begin
              r_err[ErrActActive] <= 1'b1;
            end else begin
              r_bank_active[bus.bank] <= 1'b1;
              r_open_row[bus.bank]    <= bus.address[ROW_BITS-1:0];
            end
          end
          CmdPre: begin
            if (bus.address[10]) r_bank_active <= '0;
            else                 r_bank_active[bus.bank] <= 1'b0;
          end
          CmdAr: begin
            if (|r_bank_active) r_err[ErrArActive] <= 1'b1;
            else                r_refresh_count <= r_refresh_count + 16'd1;
          end
          CmdMrs: begin
            if (mode_supported(bus.address)) begin
              r_mode_valid <= 1'b1;
              r_bl_code    <= bus.address[ModeBlLsb +: 2];
              r_cl3        <= bus.address[ModeClLsb];
            end else begin
              r_err[ErrMode] <= 1'b1;
            end
          end
          CmdRead, CmdWrite: begin
            if (!r_mode_valid) r_err[ErrMode]   <= 1'b1;
            if (!w_bank_open)  r_err[ErrRwIdle] <= 1'b1;
          end
          default: ;
        endcase
      end

      // Burst generator; beat 0 is serviced directly from the command bus
      if (w_rw_ok) begin
        r_burst_active <= (burst_len_m1(r_bl_code) != 3'd0);
        r_burst_wr     <= (w_cmd == CmdWrite);
        r_burst_bank   <= bus.bank;
        r_burst_row    <= r_open_row[bus.bank];
        r_burst_col    <= bus.address[COL_BITS-1:0];
        r_burst_idx    <= 3'd1;
        r_burst_len_m1 <= burst_len_m1(r_bl_code);
      end else if (w_stop) begin
        r_burst_active <= 1'b0;
      end else if (r_burst_active) begin
        r_burst_idx <= r_burst_idx + 3'd1;
        if (r_burst_idx == r_burst_len_m1) r_burst_active <= 1'b0;
      end

      // Read pipeline; a WRITE flushes every read beat still in flight
      if (w_wr_start) begin
        r_ram_v   <= 1'b0;
        r_mid_v   <= 1'b0;
        r_data_oe <= 1'b0;
      end else begin
        r_ram_v    <= w_rd_issue;
        r_mid_v    <= r_ram_v;
        r_mid_d    <= w_ram_rdata;
        r_data_oe  <= w_out_v;
        r_data_out <= w_out_v ? w_out_d : '0;
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.data_oe       = r_data_oe;
  assign bus.error_flags   = r_err;
  assign bus.refresh_count = r_refresh_count;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder. Inputs change and outputs are sampled on the
// falling edge; a READ accepted on rising edge E0 shows beat k at the falling edge
// just before rising edge E0+CL+k.
module tb_sdram_responder;
  localparam logic [2:0] C_MRS   = 3'b000;
  localparam logic [2:0] C_AR    = 3'b001;
  localparam logic [2:0] C_PRE   = 3'b010;
  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_BST   = 3'b110;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  sdram_responder_if bus_if ();

  sdram_responder #(
    .ROW_BITS(4),
    .COL_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                         input logic [15:0] d, input logic [1:0] m);
    bus_if.cs_n = 1'b0;
    {bus_if.ras, bus_if.cas, bus_if.we} = c;
    bus_if.bank      = b;
    bus_if.address   = a;
    bus_if.data_in   = d;
    bus_if.data_mask = m;
  endtask

  // Idle bus keeps the mask fully set so no stray byte can be written.
  task automatic set_nop();
    bus_if.cs_n = 1'b1;
    {bus_if.ras, bus_if.cas, bus_if.we} = 3'b111;
    bus_if.bank      = 2'd0;
    bus_if.address   = 12'h000;
    bus_if.data_in   = 16'h0000;
    bus_if.data_mask = 2'b11;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
    set_cmd(c, b, a, 16'h0000, 2'b11);
    tick();
    set_nop();
  endtask

  task automatic write_burst(input logic [1:0] b, input logic [11:0] col, input logic [15:0] d0,
                             input logic [15:0] step, input int n, input logic [1:0] m);
    set_cmd(C_WRITE, b, col, d0, m);
    tick();
    for (int k = 1; k < n; k++) begin
      set_nop();
      bus_if.data_in   = d0 + 16'(k) * step;
      bus_if.data_mask = m;
      tick();
    end
    set_nop();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus_if.data_oe !== 1'b0) begin
      n_fail++; $display("FAIL reset_oe: got %b want 0", bus_if.data_oe);
    end
    n_checks++;
    if (bus_if.data_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dout: got %h want 0000", bus_if.data_out);
    end
    n_checks++;
    if (bus_if.error_flags !== 4'b0000) begin
      n_fail++; $display("FAIL reset_err: got %b want 0000", bus_if.error_flags);
    end
    n_checks++;
    if (bus_if.refresh_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_refresh: got %0d want 0", bus_if.refresh_count);
    end
    rst = 1'b0;
    // READ before any MRS, to an idle bank: mode error plus idle-bank error.
    issue(C_READ, 2'd0, 12'h000);
    n_checks++;
    if (bus_if.error_flags !== 4'b1010) begin
      n_fail++; $display("FAIL read_no_mode: got %b want 1010", bus_if.error_flags);
    end
    apply_reset();
  endtask

  task automatic test_burst_rw();
    logic        exp_oe;
    logic [15:0] exp_d;
    int          oe_cycles;
    issue(C_MRS, 2'd0, 12'h023);
    issue(C_ACT, 2'd1, 12'h003);
    write_burst(2'd1, 12'h010, 16'h1000, 16'h0001, 8, 2'b00);
    issue(C_READ, 2'd1, 12'h010);
    oe_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      exp_oe = (i >= 1) && (i <= 8);
      exp_d  = 16'h1000 + 16'(i - 1);
      n_checks++;
      if (bus_if.data_oe !== exp_oe) begin
        n_fail++; $display("FAIL bl8_oe[%0d]: got %b want %b", i, bus_if.data_oe, exp_oe);
      end
      if (exp_oe) begin
        n_checks++;
        if (bus_if.data_out !== exp_d) begin
          n_fail++; $display("FAIL bl8_data[%0d]: got %h want %h", i, bus_if.data_out, exp_d);
        end
      end
      if (bus_if.data_oe === 1'b1) oe_cycles++;
      tick();
    end
    n_checks++;
    if (oe_cycles != 8) begin
      n_fail++; $display("FAIL bl8_oe_count: got %0d want 8", oe_cycles);
    end
  endtask

  task automatic test_wrap();
    logic        exp_oe;
    logic [15:0] exp_seq [2][4];
    exp_seq = '{'{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD},
                '{16'hCCCC, 16'hDDDD, 16'hAAAA, 16'hBBBB}};
    issue(C_MRS, 2'd0, 12'h032);
    write_burst(2'd1, 12'h006, 16'hAAAA, 16'h1111, 4, 2'b00);
    // Column 6 reads back in write order; column 4 proves where each beat landed.
    for (int r = 0; r < 2; r++) begin
      issue(C_READ, 2'd1, (r == 0) ? 12'h006 : 12'h004);
      for (int i = 0; i < 8; i++) begin
        exp_oe = (i >= 2) && (i <= 5);
        n_checks++;
        if (bus_if.data_oe !== exp_oe) begin
          n_fail++; $display("FAIL wrap%0d_oe[%0d]: got %b want %b", r, i, bus_if.data_oe, exp_oe);
        end
        if (exp_oe) begin
          n_checks++;
          if (bus_if.data_out !== exp_seq[r][i-2]) begin
            n_fail++;
            $display("FAIL wrap%0d_data[%0d]: got %h want %h", r, i, bus_if.data_out,
                     exp_seq[r][i-2]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_mask();
    logic exp_oe;
    write_burst(2'd1, 12'h020, 16'hFFFF, 16'h0000, 4, 2'b00);
    write_burst(2'd1, 12'h020, 16'h1234, 16'h0000, 4, 2'b01);
    issue(C_READ, 2'd1, 12'h020);
    for (int i = 0; i < 8; i++) begin
      exp_oe = (i >= 2) && (i <= 5);
      n_checks++;
      if (bus_if.data_oe !== exp_oe) begin
        n_fail++; $display("FAIL mask_oe[%0d]: got %b want %b", i, bus_if.data_oe, exp_oe);
      end
      if (exp_oe) begin
        n_checks++;
        if (bus_if.data_out !== 16'h12FF) begin
          n_fail++; $display("FAIL mask_data[%0d]: got %h want 12ff", i, bus_if.data_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_terminate();
    logic        exp_oe;
    logic [15:0] exp_d;
    int          oe_cycles;
    issue(C_MRS, 2'd0, 12'h023);
    // BST two edges after the READ: only beats 0 and 1 were issued.
    issue(C_READ, 2'd1, 12'h010);
    oe_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      exp_oe = (i == 1) || (i == 2);
      exp_d  = 16'h1000 + 16'(i - 1);
      n_checks++;
      if (bus_if.data_oe !== exp_oe) begin
        n_fail++; $display("FAIL bst_oe[%0d]: got %b want %b", i, bus_if.data_oe, exp_oe);
      end
      if (exp_oe) begin
        n_checks++;
        if (bus_if.data_out !== exp_d) begin
          n_fail++; $display("FAIL bst_data[%0d]: got %h want %h", i, bus_if.data_out, exp_d);
        end
      end
      if (bus_if.data_oe === 1'b1) oe_cycles++;
      if (i == 1) set_cmd(C_BST, 2'd0, 12'h000, 16'h0000, 2'b11);
      else        set_nop();
      tick();
    end
    n_checks++;
    if (oe_cycles != 2) begin
      n_fail++; $display("FAIL bst_oe_count: got %0d want 2", oe_cycles);
    end
    // Fully masked WRITE three edges after a READ drops data_oe on that edge.
    issue(C_READ, 2'd1, 12'h010);
    for (int i = 0; i < 12; i++) begin
      exp_oe = (i == 1) || (i == 2);
      n_checks++;
      if (bus_if.data_oe !== exp_oe) begin
        n_fail++; $display("FAIL wr_cancel_oe[%0d]: got %b want %b", i, bus_if.data_oe, exp_oe);
      end
      if (i == 2) set_cmd(C_WRITE, 2'd1, 12'h010, 16'h0000, 2'b11);
      else        set_nop();
      tick();
    end
  endtask

  task automatic test_errors();
    n_checks++;
    if (bus_if.error_flags !== 4'b0000) begin
      n_fail++; $display("FAIL err_start: got %b want 0000", bus_if.error_flags);
    end
    issue(C_ACT, 2'd1, 12'h005);
    n_checks++;
    if (bus_if.error_flags !== 4'b0001) begin
      n_fail++; $display("FAIL err_act_open: got %b want 0001", bus_if.error_flags);
    end
    issue(C_READ, 2'd2, 12'h000);
    n_checks++;
    if (bus_if.error_flags !== 4'b0011) begin
      n_fail++; $display("FAIL err_rw_idle: got %b want 0011", bus_if.error_flags);
    end
    issue(C_AR, 2'd0, 12'h000);
    n_checks++;
    if (bus_if.error_flags !== 4'b0111) begin
      n_fail++; $display("FAIL err_ar_open: got %b want 0111", bus_if.error_flags);
    end
    n_checks++;
    if (bus_if.refresh_count !== 16'd0) begin
      n_fail++; $display("FAIL err_ar_count: got %0d want 0", bus_if.refresh_count);
    end
    issue(C_MRS, 2'd0, 12'h047);
    n_checks++;
    if (bus_if.error_flags !== 4'b1111) begin
      n_fail++; $display("FAIL err_bad_mrs: got %b want 1111", bus_if.error_flags);
    end
    // Rejected MRS and ACT leave CL2/BL8 and row 3 in place.
    issue(C_READ, 2'd1, 12'h010);
    tick();
    n_checks++;
    if ((bus_if.data_oe !== 1'b1) || (bus_if.data_out !== 16'h1000)) begin
      n_fail++;
      $display("FAIL err_mode_kept: got oe=%b data=%h want oe=1 data=1000",
               bus_if.data_oe, bus_if.data_out);
    end
    for (int i = 0; i < 10; i++) tick();
    issue(C_PRE, 2'd0, 12'h400);
    n_checks++;
    if (bus_if.error_flags !== 4'b1111) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1111", bus_if.error_flags);
    end
  endtask

  task automatic test_reset_abort();
    issue(C_ACT, 2'd1, 12'h003);
    issue(C_READ, 2'd1, 12'h010);
    tick();
    n_checks++;
    if (bus_if.data_oe !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_oe: got %b want 1", bus_if.data_oe);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ((bus_if.data_oe !== 1'b0) || (bus_if.data_out !== 16'h0000)) begin
      n_fail++;
      $display("FAIL abort_out: got oe=%b data=%h want oe=0 data=0000",
               bus_if.data_oe, bus_if.data_out);
    end
    n_checks++;
    if (bus_if.error_flags !== 4'b0000) begin
      n_fail++; $display("FAIL abort_err_clear: got %b want 0000", bus_if.error_flags);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus_if.data_oe !== 1'b0) begin
        n_fail++; $display("FAIL abort_tail_oe[%0d]: got %b want 0", i, bus_if.data_oe);
      end
    end
  endtask

  task automatic test_refresh();
    issue(C_ACT, 2'd0, 12'h000);
    issue(C_PRE, 2'd3, 12'h400);
    for (int i = 0; i < 3; i++) issue(C_AR, 2'd0, 12'h000);
    n_checks++;
    if (bus_if.refresh_count !== 16'd3) begin
      n_fail++; $display("FAIL refresh_3: got %0d want 3", bus_if.refresh_count);
    end
    // Deselected, then clock-disabled AR: both ignored.
    set_cmd(C_AR, 2'd0, 12'h000, 16'h0000, 2'b11);
    bus_if.cs_n = 1'b1;
    tick();
    bus_if.cs_n = 1'b0;
    bus_if.cke  = 1'b0;
    tick();
    bus_if.cke = 1'b1;
    set_nop();
    n_checks++;
    if (bus_if.refresh_count !== 16'd3) begin
      n_fail++; $display("FAIL refresh_ignored: got %0d want 3", bus_if.refresh_count);
    end
    set_cmd(C_ACT, 2'd2, 12'h001, 16'h0000, 2'b11);
    bus_if.cs_n = 1'b1;
    tick();
    bus_if.cs_n = 1'b0;
    bus_if.cke  = 1'b0;
    tick();
    bus_if.cke = 1'b1;
    set_nop();
    issue(C_ACT, 2'd2, 12'h001);
    n_checks++;
    if (bus_if.error_flags !== 4'b0000) begin
      n_fail++; $display("FAIL ignored_act: got %b want 0000", bus_if.error_flags);
    end
    issue(C_ACT, 2'd2, 12'h001);
    n_checks++;
    if (bus_if.error_flags !== 4'b0001) begin
      n_fail++; $display("FAIL act_took: got %b want 0001", bus_if.error_flags);
    end
  endtask

  task automatic test_cke_freeze();
    logic        exp_oe;
    logic [15:0] exp_d;
    int          en_edges;
    issue(C_MRS, 2'd0, 12'h023);
    issue(C_ACT, 2'd1, 12'h003);
    issue(C_READ, 2'd1, 12'h010);
    en_edges = 0;
    for (int i = 0; i < 14; i++) begin
      exp_oe = (en_edges >= 1) && (en_edges <= 8);
      exp_d  = 16'h1000 + 16'(en_edges - 1);
      n_checks++;
      if (bus_if.data_oe !== exp_oe) begin
        n_fail++; $display("FAIL cke_oe[%0d]: got %b want %b", i, bus_if.data_oe, exp_oe);
      end
      if (exp_oe) begin
        n_checks++;
        if (bus_if.data_out !== exp_d) begin
          n_fail++; $display("FAIL cke_data[%0d]: got %h want %h", i, bus_if.data_out, exp_d);
        end
      end
      bus_if.cke = !((i >= 1) && (i <= 3));
      if (bus_if.cke) en_edges++;
      tick();
    end
    bus_if.cke = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    bus_if.cke = 1'b1;
    set_nop();
    test_reset();
    test_burst_rw();
    test_wrap();
    test_mask();
    test_terminate();
    test_errors();
    test_reset_abort();
    test_refresh();
    test_cke_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device responder for a 12-bit-address, 4-bank, x16 SDR SDRAM. It decodes the `cs_n`/`ras`/`cas`/`we` command bus that the SDRAM controller drives and services reads and writes from on-chip block RAM, honouring the loaded CAS latency and burst length. It sits at the far end of the controller's pin interface, for FPGA loopback and simulation benches. Protocol violations and refresh activity are exposed for verification.

## Interface
- `ROW_BITS`, 4: row bits stored per bank; upper row bits are ignored, so rows alias.
- `COL_BITS`, 8: column bits stored, taken from `address[COL_BITS-1:0]`.
- `clk` in 1: device clock, the same clock as the controller's SDRAM clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `cke` in 1: clock enable; when low, the command is ignored and all state holds.
- `cs_n` in 1: chip select, active low; high means NOP.
- `ras`, `cas`, `we` in 1 each: command, `{ras,cas,we}`.
- `address` in 12: row for ACT; column for READ/WRITE; A10 means all banks (PRE); mode value (MRS).
- `bank` in 2: bank select.
- `data_in` in 16: write data from the bus.
- `data_mask` in 2: byte mask; a bit that is 1 suppresses that byte of a write.
- `data_out` out 16: read data.
- `data_oe` out 1: `data_out` is valid and the top level must drive the bus.
- `error_flags` out 4: sticky violation bits.
- `refresh_count` out 16: number of accepted AUTO REFRESH commands; wraps.

## Operation
- Command codes: NOP 111, ACT 011, READ 101, WRITE 100, PRE 010, AR 001, MRS 000, BST 110.
- Commands are decoded only when `cke=1` and `cs_n=0`.
- Per-bank state is IDLE or ACTIVE, plus an open-row register.
  - ACT: IDLE→ACTIVE and latches `address[ROW_BITS-1:0]`.
  - PRE: →IDLE. With A10=1 it applies to all banks. PRE on an IDLE bank is legal and does nothing.
- MRS accepts a mode only when BL (A[2:0]) is 000/001/010/011 (1/2/4/8), A3=0, and CL (A[6:4]) is 2 or 3. An accepted mode is latched and sets `mode_valid`. Any other value sets `error_flags[3]` and leaves the mode unchanged.
- Storage word index = `{bank, open_row, col}`; depth is 4·2^ROW_BITS·2^COL_BITS.
- Burst addressing is sequential. Column low bits wrap modulo BL; upper column bits stay fixed (start at 6 with BL=4 gives 6,7,4,5).
- WRITE:
  - Beat 0 = `data_in` sampled on the command edge; beats 1..BL-1 are sampled on the following edges.
  - Each byte is written only if its `data_mask` bit is 0.
- READ: beat k of the burst appears on `data_out` with `data_oe=1`, starting CL cycles after the command edge.
- Burst termination: a new READ/WRITE, BST, or a PRE to the burst's bank stops the issue of further beats.
  - After READ, BST or PRE, read beats already issued still emerge.
  - A WRITE cancels all pending read beats.
- Errors (sticky until `rst`):
  - bit0: ACT to an ACTIVE bank.
  - bit1: READ/WRITE to an IDLE bank.
  - bit2: AR while any bank is ACTIVE.
  - bit3: READ/WRITE before a valid MRS, or an unsupported MRS.
- An erroring command is otherwise ignored. AR with all banks IDLE increments `refresh_count`.

## Timing
- Reset values:
  - Outputs: `data_out`=0, `data_oe`=0, `error_flags`=0, `refresh_count`=0.
  - Internal: all banks IDLE, `mode_valid`=0, no burst in progress, read pipeline empty.
- `rst` mid-burst aborts immediately; RAM contents are not cleared.
- The RAM is synchronous with 1-cycle read latency. The read pipeline is (CL-1) registers after the RAM, so output latency is exactly CL from the command edge.
- Back-to-back READs with a gap of BL produce a gapless `data_oe` stream.
- A READ issued mid-burst is seamless: the new beats follow the old beats already in flight.
- `cke` low freezes the burst counter and the read pipeline. `data_oe` holds its value.
- `tRCD`, `tRP` and `tRFC` are not checked.

## Structure
- Shared package `sdram_responder_pkg`:
  - command encodings (matching the existing `SDRAM_CMD_*` values),
  - mode field positions,
  - the supported-BL/CL decode function,
  - error bit indices.
- Sub-module `sdram_responder_mem`: single-port synchronous RAM with 16-bit data and two byte enables.
- Command decode, bank tracker, burst generator and read pipeline stay in the top module.

## Test plan
- Reset, then MRS 0x023 (CL2, BL8), ACT bank1 row 3, WRITE col 0x10 with data 0x1000..0x1007 and masks 00 → a READ col 0x10 at CL2 returns 0x1000..0x1007, with `data_oe` high for exactly 8 cycles.
- MRS 0x032 (CL3, BL4); WRITE col 6 with data A,B,C,D → RAM columns 6,7,4,5 hold A,B,C,D. A READ col 6 returns A,B,C,D starting 3 cycles after the command.
- WRITE 0xFFFF to a location, then WRITE 0x1234 to it with `data_mask`=01 → a subsequent read returns 0x12FF.
- READ BL8 with BST 2 cycles later (CL2) → exactly 2 beats are output. A WRITE issued while beats are pending → `data_oe` drops at once.
- Illegal sequences → error bits set:
  - ACT to an open bank → `error_flags`=0001;
  - then READ to an idle bank → 0011;
  - then AR with a bank open → 0111;
  - then MRS 0x047 → 1111.
  - Only `rst` clears them.
- PRE with A10=1, then 3 ARs → `refresh_count`=3. Commands sent with `cs_n`=1 or `cke`=0 cause no state change.
